uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter on the DE0-Nano clock domain. It sits at the UART-side end of the TX FIFO handshake: it accepts one byte while `tx_wren` is high and pulses `tx_accept` for one cycle. It then serializes the byte LSB-first onto `tx` as start bit, 8 data bits, optional parity and stop bit(s). It is the consumer that the FIFO's `tx_out_wren`/`tx_accept` protocol drives.

## Interface
- `CLKS_PER_BIT`, default 434: `sys_clk` cycles per bit (50 MHz / 115200). Must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tx_wren` in 1: byte available on `tx_data`. Held high until `tx_accept` is seen.
- `tx_data` in 8: byte to send. Valid while `tx_wren` is high.
- `tx_accept` out 1: one-cycle pulse when the byte has been latched.
- `tx` out 1: serial line. Idle level is 1.
- `tx_busy` out 1: high from accept until the end of the last stop bit.

## Operation
- Reset values: `tx`=1, `tx_accept`=0, `tx_busy`=0, state IDLE, counters 0, shift register 0.
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- **IDLE**: on an edge with `tx_wren`=1:
  - load `tx_data` into the shift register;
  - `tx_accept`<=1 for exactly one cycle;
  - `tx`<=0, `tx_busy`<=1;
  - clear the baud and bit counters;
  - go to START.
- **IDLE with `tx_wren`=0**: hold `tx`=1.
- **START**: after CLKS_PER_BIT cycles, drive bit 0 and go to DATA.
- **DATA**: each bit lasts CLKS_PER_BIT cycles; shift right; the bit counter runs 0..7.
  - After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
- **PARITY**: drive the even-parity bit for CLKS_PER_BIT cycles, then go to STOP.
- **STOP**: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles, then `tx_busy`<=0 and go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). It wraps at CLKS_PER_BIT-1 and issues a one-cycle bit-end tick.
- Bit counter: 3 bits. Stop counter: 1 bit.
- `tx_accept` is never asserted outside IDLE. `tx_wren` arriving while busy waits until IDLE; there is no drop and no overrun.
- `tx_data` is sampled only on the accept edge. Later changes have no effect on the frame in flight.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously) and the frame is truncated. After release the block is in IDLE and the byte is not resent.

## Timing
- Accept latency: `tx_accept` and the falling edge of `tx` appear on the first edge after `tx_wren` is high in IDLE.
- Frame length after accept: (1 + 8 + P + STOP_BITS) × CLKS_PER_BIT cycles, where P is 1 with the macro and 0 without.
- Minimum gap between frames: 1 cycle of idle-high after the final stop bit, because the IDLE state is visited once.
  - Back-to-back period is therefore frame length + 1 cycle.
- `tx` is registered and glitch-free; each bit boundary falls exactly on a multiple of CLKS_PER_BIT cycles from accept.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state is compiled in and an even-parity bit (XOR of the 8 data bits) is sent after bit 7.
  - Undefined: no parity state or logic; DATA goes straight to STOP.

## Structure
- Package `uart_pkg`:
  - TX state encoding;
  - default `CLKS_PER_BIT` constant (434);
  - the data-width constant 8.
- One sub-module, `uart_baud_tick`: parameterized CLKS_PER_BIT counter with `clear` input and `tick` output. It is reusable by a future RX block.

## Test plan
- **Single byte, no parity.** CLKS_PER_BIT=4, STOP_BITS=1, byte 0xA5.
  - Expect `tx` = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
  - Expect `tx_accept` high for exactly 1 cycle and `tx_busy` high for 40 cycles.
- **Parity.** `UART_TX_PARITY_EN` defined, 0xA5 then 0x07.
  - Parity bit 0 for 0xA5; parity bit 1 for 0x07.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
- **Back-to-back.** `tx_wren` held high with 0x00 then 0xFF.
  - Second `tx_accept` comes exactly 41 cycles after the first.
  - No accept occurs while `tx_busy`=1.
- **Two stop bits.** STOP_BITS=2, byte 0x55: stop level 1 for 8 cycles, frame 44 cycles.
- **Reset mid-frame.** Reset asserted during data bit 3.
  - `tx`=1 and `tx_busy`=0 immediately.
  - After release with `tx_wren`=0: no further transitions and no `tx_accept`.
- **Data stability.** `tx_data` changed from 0x3C to 0xFF one cycle after accept: the serialized bits still equal 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, default bit period, data width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Optional build macro UART_TX_PARITY_EN adds the TX_PARITY state.
package uart_pkg;

   // 50 MHz / 115200 baud
   localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
   localparam int UART_DATA_W               = 8;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;
`else
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_STOP   = 3'd4
   } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the TX FIFO (master) and the UART transmitter (slave).
// Latency: n/a (wires only).
// Backpressure: master holds tx_wren/tx_data until the slave pulses tx_accept.
// Signals: tx_wren (byte available), tx_data (byte), tx_accept (byte latched).
interface uart_tx_if;
   import uart_pkg::*;

   logic                   tx_wren;
   logic [UART_DATA_W-1:0] tx_data;
   logic                   tx_accept;

   modport master (output tx_wren, output tx_data, input  tx_accept);
   modport slave  (input  tx_wren, input  tx_data, output tx_accept);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: raises tick during the last cycle of each CLKS_PER_BIT period.
// Latency: first tick CLKS_PER_BIT-1 cycles after clear drops; then every CLKS_PER_BIT.
// Backpressure: none; clear holds the count at zero.
// Ports: sys_clk, reset (async, active low), clear (restart period), tick (bit end).
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic sys_clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over uart_tx_if and sends start, 8 data (LSB first),
// [even parity], stop bit(s). Latency: accept and start bit on the first edge with tx_wren.
// Backpressure: tx_wren is only accepted in IDLE; a pending byte waits, never dropped.
// Ports: sys_clk, reset (async, active low), bus (uart_tx_if.slave), tx (serial, idle 1),
// tx_busy (accept edge until end of last stop bit).
// Build macro UART_TX_PARITY_EN: adds an even-parity bit after data bit 7.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic       sys_clk,
   input  logic       reset,
   uart_tx_if.slave   bus,
   output logic       tx,
   output logic       tx_busy
);

   localparam logic STOP_LAST = (STOP_BITS == 2);

   tx_state_t              state;
   logic [UART_DATA_W-1:0] shreg;
   logic [2:0]             bit_cnt;
   logic                   stop_cnt;
   logic                   tick;
   logic                   tx_accept_q;
`ifdef UART_TX_PARITY_EN
   logic                   parity_q;
`endif

   // Holding the counter cleared through IDLE makes every bit boundary land on
   // an exact multiple of CLKS_PER_BIT from the accept edge.
   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .sys_clk (sys_clk),
      .reset   (reset),
      .clear   (state == TX_IDLE),
      .tick    (tick)
   );

   assign bus.tx_accept = tx_accept_q;

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         state       <= TX_IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         tx          <= 1'b1;
         tx_busy     <= 1'b0;
         tx_accept_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         tx_accept_q <= 1'b0;
         case (state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (bus.tx_wren) begin
                  shreg       <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                  // Captured now because the shift register loses the low bits.
                  parity_q    <= ^bus.tx_data;
`endif
                  tx_accept_q <= 1'b1;
                  tx          <= 1'b0;
                  tx_busy     <= 1'b1;
                  bit_cnt     <= '0;
                  stop_cnt    <= 1'b0;
                  state       <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  tx    <= shreg[0];
                  state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tick) begin
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= parity_q;
                     state <= TX_PARITY;
`else
                     tx    <= 1'b1;
                     state <= TX_STOP;
`endif
                  end else begin
                     // shreg[0] is on the line; the next bit is shreg[1].
                     tx      <= shreg[1];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
               if (tick) begin
                  tx    <= 1'b1;
                  state <= TX_STOP;
               end
            end
`endif
            TX_STOP: begin
               if (tick) begin
                  if (stop_cnt == STOP_LAST) begin
                     tx_busy <= 1'b0;
                     state   <= TX_IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               state   <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: one instance with 1 stop bit,
// one with 2 stop bits; expected frames are built from the byte values.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int CPB = 4;

   logic sys_clk = 1'b0;
   logic reset   = 1'b0;
   logic sel     = 1'b0;
   logic tx1, tx2, busy1, busy2;
   int   tests   = 0;
   int   failed  = 0;

   always #5 sys_clk = ~sys_clk;

   uart_tx_if if1 ();
   uart_tx_if if2 ();

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .sys_clk (sys_clk), .reset (reset), .bus (if1), .tx (tx1), .tx_busy (busy1));
   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .sys_clk (sys_clk), .reset (reset), .bus (if2), .tx (tx2), .tx_busy (busy2));

   logic tx_s, busy_s, acc_s;
   assign tx_s   = sel ? tx2   : tx1;
   assign busy_s = sel ? busy2 : busy1;
   assign acc_s  = sel ? if2.tx_accept : if1.tx_accept;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [7:0] d);
      if1.tx_wren = w & ~sel;
      if2.tx_wren = w & sel;
      if1.tx_data = d;
      if2.tx_data = d;
   endtask

   // Wait (bounded) for tx_accept while tx_wren is held; called at a negedge.
   task automatic wait_accept(input string tag);
      int n;
      n = 0;
      while (!acc_s && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      check({tag, "_accept"}, {31'd0, acc_s}, 32'd1);
   endtask

   // Send byte b and check every bit period, busy length and the single accept.
   task automatic run_frame(input logic [7:0] b, input int sb, input bit chg,
                            input logic [7:0] chg_val, input string tag);
      logic [11:0] exp_bits;
      logic [3:0]  samp;
      int          nb, busy_cnt, acc_cnt;
      nb       = 1 + 8 + P + sb;
      exp_bits = '1;
      exp_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits[1 + i] = b[i];
      if (P == 1) exp_bits[9] = ^b;
      drive(1'b1, b);
      wait_accept(tag);
      drive(1'b0, b);
      busy_cnt = 0;
      acc_cnt  = 0;
      for (int i = 0; i < nb; i++) begin
         samp = '0;
         for (int c = 0; c < CPB; c++) begin
            samp[c] = tx_s;
            if (busy_s) busy_cnt++;
            if (!(i == 0 && c == 0) && acc_s) acc_cnt++;
            if (chg && i == 0 && c == 1) drive(1'b0, chg_val);
            @(negedge sys_clk);
         end
         check($sformatf("%s_bit%0d", tag, i), {28'd0, samp}, {28'd0, {4{exp_bits[i]}}});
      end
      check({tag, "_busy_cycles"}, busy_cnt, nb * CPB);
      check({tag, "_extra_accepts"}, acc_cnt, 0);
      check({tag, "_busy_after"}, {31'd0, busy_s}, 32'd0);
      check({tag, "_tx_idle"}, {31'd0, tx_s}, 32'd1);
   endtask

   initial begin
      int k, trans, acc;
      logic prev_busy;
      drive(1'b0, 8'h00);
      repeat (3) @(negedge sys_clk);
      check("rst_tx1", {31'd0, tx1}, 32'd1);
      check("rst_busy1", {31'd0, busy1}, 32'd0);
      check("rst_acc1", {31'd0, if1.tx_accept}, 32'd0);
      check("rst_tx2", {31'd0, tx2}, 32'd1);
      check("rst_busy2", {31'd0, busy2}, 32'd0);
      check("rst_acc2", {31'd0, if2.tx_accept}, 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);

      run_frame(8'hA5, 1, 1'b0, 8'h00, "a5");
      repeat (2) @(negedge sys_clk);
      run_frame(8'h07, 1, 1'b0, 8'h00, "x07");
      repeat (2) @(negedge sys_clk);
      run_frame(8'h3C, 1, 1'b1, 8'hFF, "stab");
      repeat (2) @(negedge sys_clk);

      // Back-to-back: tx_wren held high across two frames.
      drive(1'b1, 8'h00);
      wait_accept("btb1");
      drive(1'b1, 8'hFF);
      k = 0;
      prev_busy = 1'b1;
      while (k < 200) begin
         prev_busy = busy_s;
         @(negedge sys_clk);
         k++;
         if (acc_s) break;
      end
      check("btb_period", k, (10 + P) * CPB + 1);
      check("btb_busy_before_accept", {31'd0, prev_busy}, 32'd0);
      drive(1'b0, 8'hFF);
      k = 0;
      while (busy_s && k < 200) begin
         @(negedge sys_clk);
         k++;
      end
      check("btb_done", {31'd0, busy_s}, 32'd0);
      repeat (2) @(negedge sys_clk);

      // Two stop bits on the second instance.
      sel = 1'b1;
      drive(1'b0, 8'h00);
      run_frame(8'h55, 2, 1'b0, 8'h00, "stop2");
      sel = 1'b0;
      drive(1'b0, 8'h00);
      repeat (2) @(negedge sys_clk);

      // Reset during data bit 3 (bit 3 of 0xF0 is 0, so the line is low).
      drive(1'b1, 8'hF0);
      wait_accept("rstmid");
      drive(1'b0, 8'hF0);
      repeat (17) @(negedge sys_clk);
      check("rstmid_tx_before", {31'd0, tx_s}, 32'd0);
      reset = 1'b0;
      #1;
      check("rstmid_tx", {31'd0, tx_s}, 32'd1);
      check("rstmid_busy", {31'd0, busy_s}, 32'd0);
      repeat (2) @(negedge sys_clk);
      reset = 1'b1;
      trans = 0;
      acc   = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sys_clk);
         if (tx_s !== 1'b1) trans++;
         if (acc_s) acc++;
      end
      check("rstmid_no_tx", trans, 0);
      check("rstmid_no_accept", acc, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
